// File: rtl/instruction_fetch.sv
// Fetch stage: streams sequential PCs into the instruction cache port, buffers
// returned words with their PCs in a small FIFO and hands them to the decoder.
module instruction_fetch #(
  parameter int ADDRESS_BITWIDTH     = 32,
  parameter int INSTRUCTION_BITWIDTH = 32,
  parameter logic [ADDRESS_BITWIDTH-1:0] RESET_ADDRESS = '0,
  parameter int FIFO_DEPTH_BITWIDTH  = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  output logic [ADDRESS_BITWIDTH-1:0]     ic_addr,
  input  logic [INSTRUCTION_BITWIDTH-1:0] ic_dout,
  input  logic                            ic_rdy,
  input  logic                            ic_bsy,
  input  logic                            redirect,
  input  logic [ADDRESS_BITWIDTH-1:0]     redirect_addr,
  output logic [INSTRUCTION_BITWIDTH-1:0] instr,
  output logic [ADDRESS_BITWIDTH-1:0]     instr_pc,
  output logic                            instr_valid,
  input  logic                            instr_ready
);

  localparam int AW    = ADDRESS_BITWIDTH;
  localparam int IW    = INSTRUCTION_BITWIDTH;
  localparam int FB    = FIFO_DEPTH_BITWIDTH;
  localparam int DEPTH = 1 << FB;
  localparam logic [FB+1:0] DEPTH_OCC = (FB+2)'(DEPTH);
  localparam logic [FB:0]   DEPTH_CNT = (FB+1)'(DEPTH);
  localparam logic [AW-1:0] PC_STEP   = AW'(4);

  typedef enum logic {FETCH, MISS} state_t;

  state_t          state;
  logic [AW-1:0]   pc;
  logic            inflight;
  logic [AW-1:0]   inflight_pc;
  logic            pending_redirect;
  logic [AW-1:0]   pending_addr;
  logic [FB:0]     count;
  logic [FB-1:0]   head;
  logic [FB-1:0]   tail;
  logic [IW-1:0]   mem_instr [DEPTH];
  logic [AW-1:0]   mem_pc    [DEPTH];

  logic            discard;
  logic            pop;
  logic            push;
  logic            issue;
  logic [FB+1:0]   occ;
  logic [FB:0]     count_next;
  logic [FB-1:0]   head_next;
  logic [FB-1:0]   tail_next;
  logic [IW-1:0]   head_instr_next;
  logic [AW-1:0]   head_pc_next;

  assign ic_addr = pc;

  always_comb begin
    discard    = redirect | pending_redirect;
    pop        = instr_valid & instr_ready & ~redirect;
    push       = ic_rdy & inflight & ~discard;
    occ        = {1'b0, count} + {{(FB+1){1'b0}}, inflight} - {{(FB+1){1'b0}}, pop};
    issue      = (state == FETCH) & ~ic_bsy & ~discard & (occ < DEPTH_OCC);
    count_next = redirect ? '0 : count + (FB+1)'(push) - (FB+1)'(pop);
    head_next  = head + FB'(pop);
    tail_next  = redirect ? head : tail + FB'(push);
    // A word pushed into an otherwise empty FIFO becomes the new head directly.
    if (push && (tail == head_next)) begin
      head_instr_next = ic_dout;
      head_pc_next    = inflight_pc;
    end else begin
      head_instr_next = mem_instr[head_next];
      head_pc_next    = mem_pc[head_next];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= FETCH;
      pc               <= RESET_ADDRESS;
      inflight         <= 1'b0;
      pending_redirect <= 1'b0;
      count            <= '0;
      head             <= '0;
      tail             <= '0;
      instr_valid      <= 1'b0;
      instr            <= '0;
      instr_pc         <= '0;
    end else begin
      count       <= count_next;
      head        <= head_next;
      tail        <= tail_next;
      instr_valid <= (count_next != '0);
      if (count_next != '0) begin
        instr    <= head_instr_next;
        instr_pc <= head_pc_next;
      end
      // A request stays outstanding through a miss until its data returns.
      inflight <= issue | (inflight & ic_bsy & ~ic_rdy);
      // While the cache is busy the address is frozen; redirects wait their turn.
      if (ic_bsy) begin
        if (redirect) pending_redirect <= 1'b1;
      end else begin
        pending_redirect <= 1'b0;
        if (redirect)              pc <= redirect_addr;
        else if (pending_redirect) pc <= pending_addr;
        else if (issue)            pc <= pc + PC_STEP;
      end
      case (state)
        FETCH:   if (ic_bsy && inflight) state <= MISS;
        MISS:    if (!ic_bsy) state <= FETCH;
        default: state <= FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[tail] <= ic_dout;
      mem_pc[tail]    <= inflight_pc;
    end
    if (issue) inflight_pc <= pc;
    if (ic_bsy && redirect) pending_addr <= redirect_addr;
  end

  // The issue throttle must leave room for every outstanding response.
  overflow_chk: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (count == DEPTH_CNT)));

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: behavioural two-line cache with a fixed word
// table, an in-order stream scoreboard and directed scenarios.
module tb_instruction_fetch;

  logic        clk;
  logic        rst;
  logic [31:0] ic_addr;
  logic [31:0] ic_dout;
  logic        ic_rdy;
  logic        ic_bsy;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  instruction_fetch #(
    .ADDRESS_BITWIDTH(32),
    .INSTRUCTION_BITWIDTH(32),
    .RESET_ADDRESS(32'h0),
    .FIFO_DEPTH_BITWIDTH(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ic_addr(ic_addr),
    .ic_dout(ic_dout),
    .ic_rdy(ic_rdy),
    .ic_bsy(ic_bsy),
    .redirect(redirect),
    .redirect_addr(redirect_addr),
    .instr(instr),
    .instr_pc(instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h00:  return 32'hB7C6A980;
      32'h08:  return 32'hAB4C3E6F;
      32'h20:  return 32'h2F5E3C7A;
      32'h40:  return 32'h4E5F6A7B;
      default: return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endcase
  endfunction

  // Cache: two 32-byte lines, round-robin replacement, fixed miss latency.
  localparam int MISS_LAT = 4;
  logic [31:0] c_addr;
  int          c_cnt;
  logic [26:0] tag [2];
  logic        tv  [2];
  logic        rp;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ic_bsy <= 1'b0; ic_rdy <= 1'b0; ic_dout <= '0; c_cnt <= 0; c_addr <= '0;
      tv[0] <= 1'b0; tv[1] <= 1'b0; rp <= 1'b0;
    end else if (ic_bsy) begin
      if (c_cnt == 0) begin
        ic_bsy <= 1'b0; ic_rdy <= 1'b1; ic_dout <= mem_word(c_addr);
        tag[rp] <= c_addr[31:5]; tv[rp] <= 1'b1; rp <= ~rp;
      end else begin
        c_cnt <= c_cnt - 1; ic_rdy <= 1'b0;
      end
    end else if ((tv[0] && tag[0] == ic_addr[31:5]) || (tv[1] && tag[1] == ic_addr[31:5])) begin
      ic_rdy <= 1'b1; ic_dout <= mem_word(ic_addr);
    end else begin
      ic_bsy <= 1'b1; ic_rdy <= 1'b0; c_cnt <= MISS_LAT; c_addr <= ic_addr;
    end
  end

  // Stream model: the decoder sees consecutive words from the latest target.
  typedef struct { logic [31:0] pc; logic [31:0] ins; int cyc; } xfer_t;
  xfer_t       got [$];
  logic [31:0] exp_pc;
  logic        flush_chk;
  logic        prev_bsy;
  logic [31:0] prev_addr;
  logic        occ_chk;

  always @(negedge clk) begin
    if (rst) begin
      exp_pc = 32'h0; flush_chk = 1'b0; prev_bsy = 1'b0;
    end else begin
      if (flush_chk) check("flush_valid", {31'b0, instr_valid}, 32'h0);
      if (prev_bsy && ic_bsy) check("addr_hold_busy", ic_addr, prev_addr);
      if (occ_chk) check("outstanding_le_2", {31'b0, (ic_addr - exp_pc) <= 32'h8}, 32'h1);
      if (redirect) begin
        exp_pc = redirect_addr; flush_chk = 1'b1;
      end else begin
        flush_chk = 1'b0;
        if (instr_valid && instr_ready) begin
          check("stream_pc", instr_pc, exp_pc);
          check("stream_instr", instr, mem_word(exp_pc));
          got.push_back('{pc: instr_pc, ins: instr, cyc: cyc});
          exp_pc = exp_pc + 32'h4;
        end
      end
      prev_bsy = ic_bsy; prev_addr = ic_addr;
    end
  end

  task automatic wait_got(input int n, input string name);
    int i = 0;
    while (got.size() < n && i < 400) begin @(posedge clk); #1; i++; end
    check(name, {31'b0, got.size() >= n}, 32'h1);
  endtask

  task automatic wait_bsy(input logic lvl, input string name);
    int i = 0;
    while (ic_bsy !== lvl && i < 200) begin @(posedge clk); #1; i++; end
    check(name, {31'b0, ic_bsy}, {31'b0, lvl});
  endtask

  task automatic pulse_redirect(input logic [31:0] a);
    redirect = 1'b1; redirect_addr = a;
    @(posedge clk); #1;
    redirect = 1'b0;
  endtask

  initial begin
    int b;
    int i;
    rst = 1'b1; redirect = 1'b0; redirect_addr = '0; instr_ready = 1'b0; occ_chk = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ic_addr", ic_addr, 32'h0);
    check("rst_valid", {31'b0, instr_valid}, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);

    // Run A: stream from reset, then redirect to 0x40 during hits.
    instr_ready = 1'b1; rst = 1'b0;
    wait_got(3, "first_three");
    check("first_pc", got[0].pc, 32'h0);
    check("first_instr", got[0].ins, 32'hB7C6A980);
    check("second_pc", got[1].pc, 32'h4);
    check("third_pc", got[2].pc, 32'h8);
    check("third_instr", got[2].ins, 32'hAB4C3E6F);
    check("pc4_pc8_back_to_back", got[2].cyc - got[1].cyc, 32'h1);
    wait_got(5, "stream_five");
    wait_bsy(1'b0, "idle_before_redirect");
    b = got.size();
    pulse_redirect(32'h40);
    check("redirect_addr_next", ic_addr, 32'h40);
    wait_got(b + 1, "after_redirect");
    check("redirect_first_pc", got[b].pc, 32'h40);
    check("redirect_first_instr", got[b].ins, 32'h4E5F6A7B);

    // Reset while the cache is busy with FIFO contents present.
    i = 0;
    while (!(ic_bsy && instr_valid) && i < 200) begin @(posedge clk); #1; i++; end
    check("busy_with_valid", {31'b0, ic_bsy && instr_valid}, 32'h1);
    rst = 1'b1;
    #1;
    check("rst_mid_miss_valid", {31'b0, instr_valid}, 32'h0);
    check("rst_mid_miss_addr", ic_addr, 32'h0);
    @(posedge clk); #1;
    b = got.size();
    rst = 1'b0;
    wait_got(b + 1, "after_mid_miss_reset");
    check("post_reset_pc", got[b].pc, 32'h0);
    check("post_reset_instr", got[b].ins, 32'hB7C6A980);

    // Run B: decoder stalled, FIFO fills and fetch stalls at 0x8.
    rst = 1'b1; instr_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    b = got.size();
    repeat (30) @(posedge clk);
    #1;
    check("stall_valid", {31'b0, instr_valid}, 32'h1);
    check("stall_head_pc", instr_pc, 32'h0);
    check("stall_ic_addr", ic_addr, 32'h8);
    repeat (5) @(posedge clk);
    #1;
    check("stall_ic_addr_held", ic_addr, 32'h8);
    check("stall_no_transfer", got.size(), b);
    instr_ready = 1'b1;
    wait_got(b + 3, "drain_three");
    check("drain_pc0", got[b].pc, 32'h0);
    check("drain_pc4", got[b+1].pc, 32'h4);
    check("drain_pc8", got[b+2].pc, 32'h8);

    // Redirect to 0x40, then to 0x20 while the 0x40 miss is outstanding.
    pulse_redirect(32'h40);
    check("redirect_40_addr", ic_addr, 32'h40);
    wait_bsy(1'b1, "miss_on_40");
    b = got.size();
    pulse_redirect(32'h20);
    wait_bsy(1'b0, "miss_40_done");
    wait_got(b + 1, "after_pending_redirect");
    check("pending_first_pc", got[b].pc, 32'h20);
    check("pending_first_instr", got[b].ins, 32'h2F5E3C7A);

    // Random decoder back-pressure over 64 instructions.
    b = got.size();
    occ_chk = 1'b1;
    i = 0;
    while (got.size() < b + 64 && i < 3000) begin
      instr_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1; i++;
    end
    occ_chk = 1'b0;
    instr_ready = 1'b1;
    check("random_64_done", {31'b0, got.size() >= b + 64}, 32'h1);
    if (got.size() >= b + 64) check("random_span", got[b+63].pc - got[b].pc, 32'd252);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage between the CPU decoder and the instruction port (port B) of the cache. Holds the program counter and streams sequential word addresses into the cache: one address per cycle on hits, the address held for the whole of a miss. Buffers returned instructions with their PCs in a small FIFO and presents them to the decoder on a valid/ready handshake. Accepts branch redirects, which flush all buffered and in-flight work.

## Interface
- ADDRESS_BITWIDTH, 32, width of PC and cache address.
- INSTRUCTION_BITWIDTH, 32, instruction width.
- RESET_ADDRESS, 0, PC after reset; must be 4-byte aligned.
- FIFO_DEPTH_BITWIDTH, 1, log2 of FIFO entries (default 2 entries).

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset, asynchronous, active-high.
- ic_addr  out  ADDRESS_BITWIDTH  address to cache port B.
- ic_dout  in  INSTRUCTION_BITWIDTH  cache instruction data.
- ic_rdy  in  1  ic_dout valid for the last accepted address.
- ic_bsy  in  1  cache busy servicing a miss; ic_addr must be held.
- redirect  in  1  one-cycle pulse; replaces the PC.
- redirect_addr  in  ADDRESS_BITWIDTH  new PC, 4-byte aligned.
- instr  out  INSTRUCTION_BITWIDTH  head-of-FIFO instruction.
- instr_pc  out  ADDRESS_BITWIDTH  PC of instr.
- instr_valid  out  1  instr/instr_pc valid.
- instr_ready  in  1  decoder consumes head when high with instr_valid.

## Operation
- Cache contract: the cache samples ic_addr every cycle.
  - Hit: ic_rdy=1 and ic_dout valid in the next cycle.
  - Miss: ic_bsy=1 from the next cycle until the fill completes. ic_rdy with data follows in the cycle ic_bsy drops, or the cycle before.
  - ic_rdy is ignored unless a request is in flight.
- State registers:
  - pc: address on ic_addr.
  - inflight: 1 bit.
  - inflight_pc: PC of the in-flight request.
  - count: 0..2^FIFO_DEPTH_BITWIDTH.
  - pending_redirect, pending_addr.
- States:
  - FETCH: issue condition is !ic_bsy && (count + inflight - pop) < depth, where pop = instr_valid && instr_ready. On issue, inflight<=1, inflight_pc<=pc, pc<=pc+4. Otherwise pc is held and inflight<=0.
  - MISS: entered when ic_bsy=1 while inflight. ic_addr is frozen and no issue occurs. Exit to FETCH when ic_bsy=0.
- Response: when ic_rdy && inflight && !discard, push {ic_dout, inflight_pc}. Space is guaranteed by the issue condition; overflow is an assertion failure.
- FIFO: circular, head/tail wrap modulo depth.
  - Push and pop in the same cycle are both allowed.
  - count = full blocks issue only; pop still proceeds.
- Redirect in FETCH:
  - FIFO is flushed (count<=0, instr_valid<=0 next cycle).
  - inflight response is discarded.
  - pc<=redirect_addr, presented on ic_addr the next cycle.
- Redirect in MISS:
  - FIFO is flushed immediately.
  - pending_redirect<=1, pending_addr latched; ic_addr stays held until ic_bsy=0.
  - The fill response is discarded, then pc<=pending_addr.
  - A later redirect before the miss ends overwrites pending_addr.
- Redirect has priority over push and pop in the same cycle. A pop in that cycle does not count as consumed by the fetch stage, and the decoder must ignore it.
- PC wraps at 2^ADDRESS_BITWIDTH without error.

## Timing
- Reset values:
  - ic_addr=RESET_ADDRESS.
  - instr_valid=0, instr=0, instr_pc=0.
  - FIFO empty; inflight=0, pending_redirect=0; state FETCH.
- Reset mid-miss returns to FETCH at once. The cache is reset by the same rst.
- Hit latency: address issued at cycle N; instruction pushed at N+1; instr_valid=1 at N+2.
- Throughput: one instruction per cycle on hits when instr_ready is held high.
- Redirect at cycle N: ic_addr=redirect_addr at N+1; first redirected instr_valid at N+3 on a hit.
- instr, instr_pc and instr_valid are registered outputs.
- ic_addr is combinational from pc.

## Test plan
Bench: BurstRAM (64-bit, 2^8 depth, 3 cycles before data, burst 4), Cache with 2 lines of 8 words, RAM.mem, fetch block on port B.
- Reset release, instr_ready=1 -> first instr_valid has instr_pc=0x0, instr=0xB7C6A980 after the miss. Then instr_pc 0x4 and 0x8 appear on consecutive cycles, with 0x8 giving 0xAB4C3E6F.
- instr_ready=0 after reset -> FIFO fills (2 entries: pc 0x0, 0x4), and ic_addr stays at 0x8 with no further push. Then raise instr_ready -> 0x0, 0x4, 0x8 are delivered in order with none lost or duplicated.
- Pulse redirect with redirect_addr=0x40 while streaming hits -> next ic_addr=0x40, and all stale entries are dropped. Next delivered instr_pc=0x40, instr=0x4E5F6A7B.
- Redirect to 0x20 during the 0x40 miss (ic_bsy=1) -> ic_addr holds 0x40 until ic_bsy=0 and the 0x40 data is never delivered. First delivered instr_pc=0x20, instr=0x2F5E3C7A (eviction path).
- Assert rst while ic_bsy=1 -> immediately instr_valid=0 and ic_addr=RESET_ADDRESS. After release, instr_pc 0x0 is delivered with 0xB7C6A980.
- Random instr_ready toggling over 64 instructions -> instr_pc strictly increments by 4, and count never exceeds 2.
